// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants, exception codes and types used by the
// index allocator and its entry table.
package rob_pkg;

    localparam int unsigned ROB_ENTRIES = 16;
    localparam int unsigned ROB_IDX_W   = 4;
    localparam int unsigned EXC_W       = 3;

    // Exception codes carried on the writeback completion port.
    localparam logic [EXC_W-1:0] EXC_NONE       = 3'b000;
    localparam logic [EXC_W-1:0] EXC_ILLEGAL    = 3'b001;
    localparam logic [EXC_W-1:0] EXC_MISALIGN   = 3'b010;
    localparam logic [EXC_W-1:0] EXC_PAGE_FAULT = 3'b011;
    localparam logic [EXC_W-1:0] EXC_ECALL      = 3'b100;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic             busy;
        logic             done;
        logic [EXC_W-1:0] exc;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry_table.sv
// Per-entry busy/done/exception storage for the ROB, with allocate,
// complete and retire write ports, a clear-all and a read port at head.
module rob_entry_table
    import rob_pkg::*;
#(
    parameter int unsigned ENTRIES = ROB_ENTRIES,
    parameter int unsigned IDX_W   = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_all,
    input  logic             alloc_en,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic             cmp_en,
    input  logic [IDX_W-1:0] cmp_idx,
    input  logic [EXC_W-1:0] cmp_exc,
    input  logic             retire_en,
    input  logic [IDX_W-1:0] head_idx,
    output rob_entry_t       head_entry_c
);

    rob_entry_t entry_q [ENTRIES];

    // Clear-all outranks every write; retire is last so it wins on the head entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            if (alloc_en) begin
                entry_q[alloc_idx].busy <= 1'b1;
                entry_q[alloc_idx].done <= 1'b0;
                entry_q[alloc_idx].exc  <= EXC_NONE;
            end
            if (cmp_en && entry_q[cmp_idx].busy) begin
                entry_q[cmp_idx].done <= 1'b1;
                entry_q[cmp_idx].exc  <= cmp_exc;
            end
            if (retire_en) begin
                entry_q[head_idx] <= '0;
            end
        end
    end

    assign head_entry_c = entry_q[head_idx];

endmodule

// File: rtl/rob_index_allocator.sv
// In-order ROB index controller: allocates tail indices to decode, retires
// completed head entries and turns a faulting head into a one-cycle flush.
module rob_index_allocator
    import rob_pkg::*;
#(
    parameter int unsigned ENTRIES = ROB_ENTRIES,
    parameter int unsigned IDX_W   = ROB_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_allocate,
    output logic [IDX_W-1:0] out_allocate_idx,
    output logic             out_alloc_ok,
    output logic             out_stall,
    input  logic             in_complete_valid,
    input  logic [IDX_W-1:0] in_complete_idx,
    input  logic [EXC_W-1:0] in_complete_exc,
    input  logic             in_flush,
    output logic             out_commit_valid,
    output logic [IDX_W-1:0] out_commit_idx,
    output logic             out_flush,
    output logic [EXC_W-1:0] out_exception_vector,
    output logic [IDX_W-1:0] out_exception_idx,
    output logic             out_full,
    output logic             out_empty
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    rob_state_e       state_q;
    rob_entry_t       head_entry_c;

    logic run_c;
    logic head_ready_c;
    logic exc_hit_c;
    logic commit_c;
    logic clear_c;

    assign run_c            = (state_q == RUN);
    assign out_allocate_idx = tail_q;
    assign out_stall        = out_full | ~run_c;
    assign out_alloc_ok     = in_allocate & ~out_full & run_c & ~in_flush;

    // An external flush suppresses head evaluation entirely for this cycle.
    assign head_ready_c = run_c & ~in_flush & head_entry_c.busy & head_entry_c.done;
    assign exc_hit_c    = head_ready_c & (head_entry_c.exc != EXC_NONE);
    assign commit_c     = head_ready_c & (head_entry_c.exc == EXC_NONE);
    assign clear_c      = in_flush | exc_hit_c;

    rob_entry_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk          (clk),
        .reset        (reset),
        .clear_all    (clear_c),
        .alloc_en     (out_alloc_ok),
        .alloc_idx    (tail_q),
        .cmp_en       (in_complete_valid),
        .cmp_idx      (in_complete_idx),
        .cmp_exc      (in_complete_exc),
        .retire_en    (commit_c),
        .head_idx     (head_q),
        .head_entry_c (head_entry_c)
    );

    // Occupancy after this cycle's allocate/commit, or zero on any flush.
    always_comb begin
        count_d = count_q;
        if (clear_c) begin
            count_d = '0;
        end else if (out_alloc_ok && !commit_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!out_alloc_ok && commit_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= RUN;
            head_q               <= '0;
            tail_q               <= '0;
            count_q              <= '0;
            out_full             <= 1'b0;
            out_empty            <= 1'b1;
            out_commit_valid     <= 1'b0;
            out_commit_idx       <= '0;
            out_flush            <= 1'b0;
            out_exception_vector <= EXC_NONE;
            out_exception_idx    <= '0;
        end else begin
            // FLUSH is a single cycle; an external flush always lands in RUN.
            state_q <= exc_hit_c ? FLUSH : RUN;

            if (clear_c) begin
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (commit_c) begin
                    head_q <= head_q + IDX_W'(1);
                end
                if (out_alloc_ok) begin
                    tail_q <= tail_q + IDX_W'(1);
                end
            end

            count_q   <= count_d;
            out_full  <= (count_d == CNT_W'(ENTRIES));
            out_empty <= (count_d == '0);

            out_commit_valid <= commit_c;
            out_commit_idx   <= commit_c ? head_q : '0;

            out_flush            <= exc_hit_c;
            out_exception_vector <= exc_hit_c ? head_entry_c.exc : EXC_NONE;
            out_exception_idx    <= exc_hit_c ? head_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(ENTRIES));
        end
    end

endmodule

// File: tb/tb_rob_index_allocator.sv
// Directed bench for rob_index_allocator: queue-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_rob_index_allocator;
    import rob_pkg::*;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_allocate = 1'b0;
    logic [3:0] out_allocate_idx;
    logic       out_alloc_ok;
    logic       out_stall;
    logic       in_complete_valid = 1'b0;
    logic [3:0] in_complete_idx = 4'd0;
    logic [2:0] in_complete_exc = 3'd0;
    logic       in_flush = 1'b0;
    logic       out_commit_valid;
    logic [3:0] out_commit_idx;
    logic       out_flush;
    logic [2:0] out_exception_vector;
    logic [3:0] out_exception_idx;
    logic       out_full;
    logic       out_empty;

    always #5 clk = ~clk;

    rob_index_allocator dut (
        .clk                  (clk),
        .reset                (reset),
        .in_allocate          (in_allocate),
        .out_allocate_idx     (out_allocate_idx),
        .out_alloc_ok         (out_alloc_ok),
        .out_stall            (out_stall),
        .in_complete_valid    (in_complete_valid),
        .in_complete_idx      (in_complete_idx),
        .in_complete_exc      (in_complete_exc),
        .in_flush             (in_flush),
        .out_commit_valid     (out_commit_valid),
        .out_commit_idx       (out_commit_idx),
        .out_flush            (out_flush),
        .out_exception_vector (out_exception_vector),
        .out_exception_idx    (out_exception_idx),
        .out_full             (out_full),
        .out_empty            (out_empty)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: live indices in program order, plus completion info.
    int q[$];
    int m_tail = 0;
    bit m_flushing = 1'b0;
    bit m_done [N];
    int m_exc  [N];
    int e_cv = 0, e_ci = 0, e_fl = 0, e_vec = 0, e_eidx = 0;
    int hd, ci;
    bit m_ok, m_rdy, m_ex, m_com;

    function automatic bit live(int idx);
        foreach (q[i]) if (q[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_tail = 0;
            m_flushing = 1'b0;
            e_cv = 0; e_ci = 0; e_fl = 0; e_vec = 0; e_eidx = 0;
            for (int i = 0; i < N; i++) begin
                m_done[i] = 1'b0;
                m_exc[i]  = 0;
            end
        end else begin
            hd    = (q.size() > 0) ? q[0] : 0;
            m_ok  = in_allocate && (q.size() != N) && !m_flushing && !in_flush;
            m_rdy = !m_flushing && !in_flush && (q.size() > 0) && m_done[hd];
            m_ex  = m_rdy && (m_exc[hd] != 0);
            m_com = m_rdy && (m_exc[hd] == 0);
            e_cv   = int'(m_com);
            e_ci   = m_com ? hd : 0;
            e_fl   = int'(m_ex);
            e_vec  = m_ex ? m_exc[hd] : 0;
            e_eidx = m_ex ? hd : 0;
            if (in_flush || m_ex) begin
                q.delete();
                m_tail = 0;
                for (int i = 0; i < N; i++) begin
                    m_done[i] = 1'b0;
                    m_exc[i]  = 0;
                end
                m_flushing = m_ex;
            end else begin
                m_flushing = 1'b0;
                ci = int'(in_complete_idx);
                if (in_complete_valid && live(ci)) begin
                    m_done[ci] = 1'b1;
                    m_exc[ci]  = int'(in_complete_exc);
                end
                if (m_com) begin
                    void'(q.pop_front());
                    m_done[hd] = 1'b0;
                    m_exc[hd]  = 0;
                end
                if (m_ok) begin
                    q.push_back(m_tail);
                    m_done[m_tail] = 1'b0;
                    m_exc[m_tail]  = 0;
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_alloc_idx", 32'(out_allocate_idx), 32'(m_tail));
            chk("m_alloc_ok", 32'(out_alloc_ok),
                32'(in_allocate && (q.size() != N) && !m_flushing && !in_flush));
            chk("m_stall", 32'(out_stall), 32'((q.size() == N) || m_flushing));
            chk("m_commit_valid", 32'(out_commit_valid), 32'(e_cv));
            chk("m_commit_idx", 32'(out_commit_idx), 32'(e_ci));
            chk("m_flush", 32'(out_flush), 32'(e_fl));
            chk("m_exc_vec", 32'(out_exception_vector), 32'(e_vec));
            chk("m_exc_idx", 32'(out_exception_idx), 32'(e_eidx));
            chk("m_full", 32'(out_full), 32'(q.size() == N));
            chk("m_empty", 32'(out_empty), 32'(q.size() == 0));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_allocate       = 1'b0;
        in_complete_valid = 1'b0;
        in_complete_idx   = 4'd0;
        in_complete_exc   = 3'd0;
        in_flush          = 1'b0;
    endtask

    task automatic alloc_n(int n);
        in_allocate = 1'b1;
        repeat (n) tick();
        in_allocate = 1'b0;
    endtask

    task automatic complete(int idx, int exc);
        in_complete_valid = 1'b1;
        in_complete_idx   = 4'(idx);
        in_complete_exc   = 3'(exc);
        tick();
        in_complete_valid = 1'b0;
    endtask

    task automatic ext_flush();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("rst_empty", 32'(out_empty), 32'd1);
        chk("rst_full", 32'(out_full), 32'd0);
        chk("rst_idx", 32'(out_allocate_idx), 32'd0);
        chk("rst_commit", 32'(out_commit_valid), 32'd0);
        chk("rst_flush", 32'(out_flush), 32'd0);
        tick();
        reset = 1'b0;

        // In-order commit of out-of-order completions.
        for (int i = 0; i < 3; i++) begin
            in_allocate = 1'b1;
            #1;
            chk("t1_idx", 32'(out_allocate_idx), 32'(i));
            chk("t1_ok", 32'(out_alloc_ok), 32'd1);
            tick();
        end
        in_allocate = 1'b0;
        complete(1, 0);
        complete(0, 0);
        complete(2, 0);
        chk("t1_c0_valid", 32'(out_commit_valid), 32'd1);
        chk("t1_c0_idx", 32'(out_commit_idx), 32'd0);
        tick();
        chk("t1_c1_idx", 32'(out_commit_idx), 32'd1);
        tick();
        chk("t1_c2_idx", 32'(out_commit_idx), 32'd2);
        chk("t1_empty", 32'(out_empty), 32'd1);
        tick();
        chk("t1_quiet", 32'(out_commit_valid), 32'd0);

        // Fill to full, refuse the 17th, free one slot and wrap.
        ext_flush();
        in_allocate = 1'b1;
        repeat (16) tick();
        #1;
        chk("t2_full", 32'(out_full), 32'd1);
        chk("t2_stall", 32'(out_stall), 32'd1);
        chk("t2_ok17", 32'(out_alloc_ok), 32'd0);
        complete(0, 0);
        chk("t2_ok_same_cycle", 32'(out_alloc_ok), 32'd0);
        tick();
        chk("t2_commit0", 32'(out_commit_valid), 32'd1);
        chk("t2_full_clr", 32'(out_full), 32'd0);
        chk("t2_wrap_idx", 32'(out_allocate_idx), 32'd0);
        chk("t2_wrap_ok", 32'(out_alloc_ok), 32'd1);
        tick();
        in_allocate = 1'b0;
        chk("t2_refull", 32'(out_full), 32'd1);
        ext_flush();
        chk("t2_drained", 32'(out_empty), 32'd1);

        // Faulting head becomes a one-cycle exception flush.
        alloc_n(4);
        complete(0, 3'b010);
        chk("t3_pre_flush", 32'(out_flush), 32'd0);
        tick();
        chk("t3_flush", 32'(out_flush), 32'd1);
        chk("t3_vec", 32'(out_exception_vector), 32'd2);
        chk("t3_eidx", 32'(out_exception_idx), 32'd0);
        chk("t3_no_commit", 32'(out_commit_valid), 32'd0);
        chk("t3_ptr", 32'(out_allocate_idx), 32'd0);
        in_allocate = 1'b1;
        #1;
        chk("t3_stall", 32'(out_stall), 32'd1);
        chk("t3_ok", 32'(out_alloc_ok), 32'd0);
        tick();
        in_allocate = 1'b0;
        chk("t3_flush_end", 32'(out_flush), 32'd0);
        chk("t3_empty", 32'(out_empty), 32'd1);

        // External flush discards same-cycle allocate and completion.
        alloc_n(2);
        in_flush = 1'b1;
        in_allocate = 1'b1;
        in_complete_valid = 1'b1;
        in_complete_idx = 4'd0;
        #1;
        chk("t4_ok", 32'(out_alloc_ok), 32'd0);
        tick();
        idle_inputs();
        chk("t4_empty", 32'(out_empty), 32'd1);
        chk("t4_idx", 32'(out_allocate_idx), 32'd0);
        chk("t4_no_exc_flush", 32'(out_flush), 32'd0);
        alloc_n(1);
        tick();
        tick();
        chk("t4_no_stale_commit", 32'(out_commit_valid), 32'd0);
        ext_flush();

        // Completions to non-busy indices are ignored.
        alloc_n(2);
        complete(7, 0);
        complete(5, 3'b101);
        tick();
        tick();
        chk("t5_commit", 32'(out_commit_valid), 32'd0);
        chk("t5_flush", 32'(out_flush), 32'd0);
        chk("t5_idx", 32'(out_allocate_idx), 32'd2);
        chk("t5_empty", 32'(out_empty), 32'd0);
        ext_flush();

        // Asynchronous reset with live entries and a pending exception.
        alloc_n(5);
        complete(0, 3'b011);
        #2 reset = 1'b1;
        #1;
        chk("t6_idx", 32'(out_allocate_idx), 32'd0);
        chk("t6_empty", 32'(out_empty), 32'd1);
        chk("t6_full", 32'(out_full), 32'd0);
        chk("t6_stall", 32'(out_stall), 32'd0);
        tick();
        chk("t6_flush", 32'(out_flush), 32'd0);
        reset = 1'b0;
        in_allocate = 1'b1;
        #1;
        chk("t6_first_idx", 32'(out_allocate_idx), 32'd0);
        chk("t6_first_ok", 32'(out_alloc_ok), 32'd1);
        tick();
        in_allocate = 1'b0;
        chk("t6_next_idx", 32'(out_allocate_idx), 32'd1);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_index_allocator.md
Name: rob_index_allocator

Overview:
- In-order reorder-buffer index controller between decode and writeback/commit.
- Hands decode the next free ROB index and tracks completion per entry from writeback.
- Retires completed entries in order and converts a faulting head entry into a one-cycle pipeline flush with its exception vector.
- Produces the decode stall when the ROB is full or a flush is in progress.

Parameters:
- ENTRIES, 16, number of ROB entries; must be a power of two.
- IDX_W, 4, index width; equals log2(ENTRIES).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_allocate  in  1  decode requests one entry this cycle.
- out_allocate_idx  out  IDX_W  index granted to decode; equals tail pointer, combinational.
- out_alloc_ok  out  1  allocation accepted this cycle.
- out_stall  out  1  decode must hold; high when full, or when state is not RUN.
- in_complete_valid  in  1  writeback completion strobe.
- in_complete_idx  in  IDX_W  ROB index being completed.
- in_complete_exc  in  3  exception vector of the completing instruction; 0 means none.
- in_flush  in  1  external flush, e.g. taken branch.
- out_commit_valid  out  1  head entry retired this cycle.
- out_commit_idx  out  IDX_W  index retired.
- out_flush  out  1  exception flush pulse.
- out_exception_vector  out  3  vector of the faulting head; valid with out_flush.
- out_exception_idx  out  IDX_W  index of the faulting entry.
- out_full  out  1  count == ENTRIES, registered.
- out_empty  out  1  count == 0, registered.

Behaviour:
- Reset (asynchronous, any cycle, mid-operation included):
  - head = 0, tail = 0, count = 0.
  - All busy, done and exc fields cleared; state = RUN.
  - out_full = 0, out_empty = 1; out_commit_valid, out_flush, out_exception_vector and out_exception_idx = 0.
- Per-entry state: busy, done, exc[2:0]. count is IDX_W+1 bits wide. Pointers wrap modulo ENTRIES (natural IDX_W-bit overflow).
- States:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle, then returns to RUN.
- Event priority: reset > in_flush > exception detection > normal allocate/complete/commit.
- Allocation:
  - out_alloc_ok = in_allocate & ~out_full & (state == RUN) & ~in_flush.
  - On accept: entry[tail] gets busy = 1, done = 0, exc = 0; tail increments.
  - Uses the registered full flag: while full, allocation is refused even if a commit frees a slot in the same cycle.
- Completion:
  - When in_complete_valid is high and entry[in_complete_idx].busy is set, the entry gets done = 1 and exc = in_complete_exc, visible next cycle.
  - Completion to a non-busy index is ignored with no side effects.
  - Completion to the head index in cycle N can commit no earlier than cycle N+1.
- Commit (RUN only): when entry[head] is busy, done and has exc == 0:
  - out_commit_valid = 1 (registered, asserted the cycle after the decision); out_commit_idx = head.
  - Clear busy on the head entry; head increments.
  - At most one commit per cycle.
- Exception (RUN, head busy and done with exc != 0):
  - Head does not commit. Next cycle, state = FLUSH and out_flush = 1 for exactly one cycle, with out_exception_vector = exc and out_exception_idx = head.
  - On entering FLUSH, all entries are cleared and head = tail = count = 0.
  - out_stall stays high throughout FLUSH.
- External in_flush:
  - Next cycle: all entries cleared, head = tail = count = 0, state = RUN.
  - Same-cycle allocate, complete and commit are discarded.
  - out_flush is not asserted; it signals exceptions only.
- Count:
  - +1 on accepted allocation, −1 on commit; unchanged when both occur in the same cycle.
  - out_full and out_empty are registered from the next-state count.
- Underflow and overflow are impossible by construction. A simulation assertion flags count > ENTRIES.

Decomposition:
- Shared package rob_pkg holds:
  - ROB_ENTRIES and ROB_IDX_W.
  - EXC_NONE = 3'b000, plus the existing exception code constants.
  - The state enum: RUN, FLUSH.
- One natural sub-module, rob_entry_table. It holds the busy/done/exc arrays, with write ports for allocate and complete, a clear-all input, and a read port at head.
- Pointer, count and FSM logic remain in the top module.

Test Plan:
- Allocate 3 entries, then complete idx 1, 0, 2 in that order, all with exc 0 → commits occur in order 0, 1, 2. Commit 0 appears one cycle after completion of 0; out_empty = 1 at the end.
- Allocate 16 consecutive entries → out_full = 1 and out_stall = 1. A 17th in_allocate gets out_alloc_ok = 0. Complete and commit idx 0 → full clears the next cycle; the next allocation gets idx 0 (wrap).
- Allocate 4 entries; complete idx 0 with exc = 3'b010 → one-cycle out_flush with vector 3'b010 and out_exception_idx 0. Pointers are 0 afterwards and there is no commit of idx 0.
- Issue in_flush in the same cycle as an allocate and a completion → out_alloc_ok = 0. Next cycle count = 0, head = tail = 0, out_flush stays 0.
- Complete an idx that was never allocated (idx 7 with 2 entries live) → no state change and no commit.
- Assert reset mid-stream with 5 live entries and a pending flush → all outputs at reset values immediately (asynchronous). After release, the first allocation gets idx 0.
